charbuf_writer: RTL
===================

# charbuf_writer

Write-side driver for the 32x32 monochrome character buffer: accepts a byte stream of character codes and control codes over a valid/ready handshake, maintains a text cursor, and issues single-cycle writes to the buffer's write port (address, data, write-enable). It sits between any character source (UART receiver, test pattern generator, CPU) and the buffer, while the VGA text renderer reads the other port. The block handles CR, LF, backspace and form-feed, and auto-wraps rows.

## Interface
- COLS, 32, characters per row; power of two.
- ROWS, 32, rows on screen; power of two.
- ADDR_W, 10, buffer address width; equals log2(COLS*ROWS).
- clk  input  1  single clock; also clocks the buffer write port.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  character or control code.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready.
- wr_en  output  1  one-cycle buffer write strobe (drives buffer write clock-enable).
- wr_addr  output  ADDR_W  write address = row*COLS + col.
- wr_data  output  8  write data.
- cur_row  output  log2(ROWS)  current cursor row.
- cur_col  output  log2(COLS)  current cursor column.

## Operation
- States: IDLE, CLR_LINE, CLR_ALL. in_ready = (state == IDLE); all outputs registered.
- Printable (code >= 0x20, except 0x7F): write code at (cur_row, cur_col); col+1. At col COLS-1: col->0, row->row+1 (ROWS-1 wraps to 0), enter CLR_LINE for the new row.
- 0x0D CR: col->0, no write.
- 0x0A LF: row->row+1 (wrap ROWS-1 -> 0), col unchanged, enter CLR_LINE for the new row.
- 0x08 BS: col->col-1 if col > 0, else no-op; no write.
- 0x0C FF: enter CLR_ALL; cursor -> (0,0).
- Other codes < 0x20 and 0x7F: consumed, no effect.
- CLR_LINE: COLS writes of 0x20 to addresses row*COLS+0 .. row*COLS+COLS-1, ascending, then IDLE.
- CLR_ALL: COLS*ROWS writes of 0x20 to addresses 0 .. COLS*ROWS-1, ascending, then IDLE.
- Address arithmetic is unsigned and wraps modulo COLS*ROWS; the clear counter is ADDR_W bits.
- Reset mid-clear aborts the clear. The partially cleared region is left as-is.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cur_row=0, cur_col=0, state IDLE (in_ready=1), except as set in Configuration.
- A code is accepted in cycle N; its write (wr_en=1) occurs in cycle N+1. Cursor outputs show the updated position in N+1.
- Back-to-back printables not at the last column: one accepted per cycle, one write per cycle.
- LF accepted at N: clear writes at N+1..N+COLS; in_ready=0 from N+1; IDLE with in_ready=1 at N+COLS+1.
- Printable at last column accepted at N: character write at N+1; clear writes at N+2..N+COLS+1; in_ready=0 from N+1; in_ready=1 at N+COLS+2.
- FF accepted at N: clear writes at N+1..N+COLS*ROWS; in_ready=1 at N+COLS*ROWS+1.
- wr_en is 0 in every cycle with no write. wr_addr and wr_data hold their last value when wr_en=0.
- No write is lost: the block never accepts while in a clear state.

## Configuration
- CHARBUF_WRITER_CLS_ON_RESET_EN defined:
  - On reset release, the block enters CLR_ALL.
  - in_ready stays 0 for COLS*ROWS cycles while 0x20 is written to every address, then goes to 1.
  - During reset, in_ready reads 0.
- CHARBUF_WRITER_CLS_ON_RESET_EN undefined:
  - The block starts in IDLE with in_ready=1.
  - Buffer contents are left at their power-up initial values.

## Test plan
- Reset, then send "AB" on consecutive cycles -> writes 0x41 at addr 0 and 0x42 at addr 1 on consecutive cycles; cursor ends at (0,2).
- Send 33 'X' from (0,0) -> 32 writes at addr 0..31; then 32 writes of 0x20 at 32..63 with in_ready=0; 33rd 'X' written at addr 32; cursor ends at (1,1).
- Cursor at (31,5), send LF -> 0x20 written to addr 0..31; cursor (0,5). Then CR, BS -> cursor (0,0), no writes.
- Send FF mid-screen -> exactly 1024 writes of 0x20 to addr 0..1023; in_ready=1 at cycle 1025 after accept; cursor (0,0).
- Assert reset during CLR_ALL at write 500 -> outputs take reset values immediately; the next FF performs a full 1024-write clear.
- With CHARBUF_WRITER_CLS_ON_RESET_EN defined: release reset -> 1024 clear writes, in_ready=0 throughout; first accepted 'A' is written at addr 0.

Source files
------------

// File: rtl/charbuf_writer.sv
// Byte-stream writer for the 32x32 character buffer: cursor, control codes, line/screen clears.
// Build option: CHARBUF_WRITER_CLS_ON_RESET_EN clears the whole screen after reset.
module charbuf_writer #(
    parameter int COLS   = 32,
    parameter int ROWS   = 32,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [7:0]              wr_data,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [7:0]        SPACE     = 8'h20;
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ALL_LAST  = ADDR_W'(COLS * ROWS - 1);
    localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_ALL
    } state_t;

`ifdef CHARBUF_WRITER_CLS_ON_RESET_EN
    localparam state_t RST_STATE = CLR_ALL;
    localparam logic   RST_READY = 1'b0;
`else
    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_n;
    logic              clr_done;
    logic              clr_done_n;
    logic              in_ready_n;
    logic              wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [7:0]        wr_data_n;
    logic [RW-1:0]     row_n;
    logic [CW-1:0]     col_n;

    logic              accept;
    logic              is_print;
    logic              is_cr;
    logic              is_lf;
    logic              is_bs;
    logic              is_ff;
    logic [RW-1:0]     row_inc;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] next_base;

    assign accept   = in_valid && in_ready;
    assign is_print = (in_data >= 8'h20) && (in_data != 8'h7F);
    assign is_cr    = (in_data == 8'h0D);
    assign is_lf    = (in_data == 8'h0A);
    assign is_bs    = (in_data == 8'h08);
    assign is_ff    = (in_data == 8'h0C);

    assign row_inc   = cur_row + RW'(1);
    assign cur_addr  = ADDR_W'({cur_row, cur_col});
    assign line_base = ADDR_W'({cur_row, CW'(0)});
    assign next_base = ADDR_W'({row_inc, CW'(0)});

    // Clears issue their first write on the entering edge when nothing else
    // occupies the write port, so the counter then starts at 1.
    always_comb begin
        state_n    = state;
        clr_cnt_n  = clr_cnt;
        clr_done_n = clr_done;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        row_n      = cur_row;
        col_n      = cur_col;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_print: begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = cur_addr;
                            wr_data_n = in_data;
                            if (cur_col == COL_LAST) begin
                                col_n      = '0;
                                row_n      = row_inc;
                                state_n    = CLR_LINE;
                                clr_cnt_n  = '0;
                                clr_done_n = 1'b0;
                            end else begin
                                col_n = cur_col + CW'(1);
                            end
                        end
                        is_cr: begin
                            col_n = '0;
                        end
                        is_lf: begin
                            row_n      = row_inc;
                            state_n    = CLR_LINE;
                            wr_en_n    = 1'b1;
                            wr_addr_n  = next_base;
                            wr_data_n  = SPACE;
                            clr_cnt_n  = ADDR_W'(1);
                            clr_done_n = 1'b0;
                        end
                        is_bs: begin
                            if (cur_col != '0) begin
                                col_n = cur_col - CW'(1);
                            end
                        end
                        is_ff: begin
                            row_n      = '0;
                            col_n      = '0;
                            state_n    = CLR_ALL;
                            wr_en_n    = 1'b1;
                            wr_addr_n  = '0;
                            wr_data_n  = SPACE;
                            clr_cnt_n  = ADDR_W'(1);
                            clr_done_n = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            CLR_LINE, CLR_ALL: begin
                if (clr_done) begin
                    state_n = IDLE;
                end else begin
                    wr_en_n   = 1'b1;
                    wr_data_n = SPACE;
                    clr_cnt_n = clr_cnt + ADDR_W'(1);
                    if (state == CLR_LINE) begin
                        wr_addr_n  = line_base + clr_cnt;
                        clr_done_n = (clr_cnt == LINE_LAST);
                    end else begin
                        wr_addr_n  = clr_cnt;
                        clr_done_n = (clr_cnt == ALL_LAST);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RST_STATE;
            clr_cnt  <= '0;
            clr_done <= 1'b0;
            in_ready <= RST_READY;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
        end else begin
            state    <= state_n;
            clr_cnt  <= clr_cnt_n;
            clr_done <= clr_done_n;
            in_ready <= in_ready_n;
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            cur_row  <= row_n;
            cur_col  <= col_n;
        end
    end

endmodule
